automata_stage_collector: RTL and testbench
===========================================

AUTOMATA_STAGE_COLLECTOR -- requirements
Module: automata_stage_collector

Interface
REQ-001 Parameter SYMBOL_W, default 8, symbol stream width in bits.
REQ-002 Parameter NUM_REPORTS, default 52, number of automaton report lines collected.
REQ-003 Parameter CNT_W, default 16, hit counter width.
REQ-004 Parameter TS_W, default 32, cycle timestamp width.
REQ-005 clk  in  1  single clock; all state SHALL update on rising edge only.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 run  in  1  stream advance enable; report_in sampled only when 1.
REQ-008 top_symbols  in  SYMBOL_W  incoming symbol.
REQ-009 report_in  in  NUM_REPORTS  per-cycle automaton report lines.
REQ-010 clear_sticky  in  1  single-cycle clear of sticky_reports.
REQ-011 rec_ack  in  1  consumer accepts current record.
REQ-012 out_symbols  out  SYMBOL_W  registered symbol to next stage.
REQ-013 out_reset  out  1  registered reset to next stage.
REQ-014 out_run  out  1  registered run to next stage.
REQ-015 sticky_reports  out  NUM_REPORTS  accumulated report bits.
REQ-016 hit_count  out  CNT_W  saturating count of cycles with any report.
REQ-017 rec_valid  out  1  record pending.
REQ-018 rec_index  out  clog2(NUM_REPORTS)  lowest set report index at capture.
REQ-019 rec_overflow  out  1  sticky: a hit was dropped while record pending.

Function
REQ-020 out_symbols SHALL load top_symbols one cycle after a run=1 edge and hold otherwise; out_reset and out_run SHALL load reset and run every cycle, regardless of run.
REQ-021 Hit SHALL be run=1 AND |report_in; non-run cycles SHALL never affect sticky, count, record or timestamp.
REQ-022 sticky_reports SHALL become (clear_sticky ? 0 : sticky_reports) OR (hit-cycle report_in), 1-cycle latency; same-cycle clear and report leaves only new bits set.
REQ-023 hit_count SHALL increment by 1 per hit cycle and stick at all-ones.
REQ-024 Record FSM states IDLE, PEND; IDLE->PEND on hit, capturing rec_index; rec_valid=1 exactly in PEND.
REQ-025 PEND->IDLE on rec_ack with no hit; rec_ack with hit SHALL stay PEND and capture the new hit (back-to-back, no bubble).
REQ-026 Hit in PEND without rec_ack SHALL keep the held record unchanged and set rec_overflow; rec_overflow clears only on reset.
REQ-027 rec_ack in IDLE SHALL be ignored.
REQ-028 rec_index SHALL be the lowest-numbered set bit of report_in; held stable while rec_valid=1.

Reset
REQ-029 On reset=1 at an edge: out_symbols=0, out_reset=1, out_run=0, sticky_reports=0, hit_count=0, FSM=IDLE, rec_valid=0, rec_index=0, rec_overflow=0, timestamp=0; reset SHALL override run, report_in, rec_ack, clear_sticky.
REQ-030 Reset asserted while PEND SHALL discard the record without an ack.

Configuration
REQ-031 Macro AUTOMATA_STAGE_TIMESTAMP_EN: when defined, add output rec_time (TS_W), a free-running counter incrementing each run=1 cycle (wraps modulo 2^TS_W), captured into rec_time alongside rec_index.
REQ-032 Without AUTOMATA_STAGE_TIMESTAMP_EN, rec_time port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 run=1, top_symbols=0x41 then run=0 for 3 cycles -> out_symbols=0x41 held all 3 cycles; out_run follows run delayed by 1.
REQ-034 run=1, report_in bits 5 and 9 set one cycle -> rec_valid=1, rec_index=5, sticky bits 5,9 set, hit_count=1.
REQ-035 Record pending, hit on bit 3 without ack -> rec_index stays 5, rec_overflow=1; then ack with hit on bit 7 -> rec_valid stays 1, rec_index=7.
REQ-036 CNT_W=4, 20 consecutive hit cycles -> hit_count=15; clear_sticky with report bit 2 -> sticky == only bit 2.
REQ-037 Reset pulse while PEND with run=1 -> next cycle rec_valid=0, all counters 0, out_reset=1.
REQ-038 With AUTOMATA_STAGE_TIMESTAMP_EN, run=1 from reset, first hit on 10th run cycle -> rec_time=9; run=0 gaps do not advance it.

Source files
------------

// File: rtl/automata_stage_collector.sv
// rtl/automata_stage_collector.sv - automaton stage pass-through with sticky report, hit counter and record capture
// Optional macro AUTOMATA_STAGE_TIMESTAMP_EN adds a run-cycle timestamp captured into rec_time.
module automata_stage_collector #(
    parameter int SYMBOL_W    = 8,
    parameter int NUM_REPORTS = 52,
    parameter int CNT_W       = 16,
    parameter int TS_W        = 32,
    localparam int IDX_W      = (NUM_REPORTS > 1) ? $clog2(NUM_REPORTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [SYMBOL_W-1:0]    top_symbols,
    input  logic [NUM_REPORTS-1:0] report_in,
    input  logic                   clear_sticky,
    input  logic                   rec_ack,
    output logic [SYMBOL_W-1:0]    out_symbols,
    output logic                   out_reset,
    output logic                   out_run,
    output logic [NUM_REPORTS-1:0] sticky_reports,
    output logic [CNT_W-1:0]       hit_count,
    output logic                   rec_valid,
    output logic [IDX_W-1:0]       rec_index,
`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
    output logic [TS_W-1:0]        rec_time,
`endif
    output logic                   rec_overflow
);

    typedef enum logic {IDLE, PEND} rec_state_t;

    rec_state_t             state_q;
    logic [SYMBOL_W-1:0]    symbols_q;
    logic                   reset_q;
    logic                   run_q;
    logic [NUM_REPORTS-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]       hit_count_q, hit_count_d;
    logic                   rec_valid_q;
    logic [IDX_W-1:0]       rec_index_q;
    logic                   rec_overflow_q;
    logic                   hit;
    logic [IDX_W-1:0]       hit_index;

    assign hit = run & (|report_in);

    // Lowest-numbered set report line; scanning downward lets the lowest win.
    always_comb begin
        hit_index = '0;
        for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
            if (report_in[i]) begin
                hit_index = IDX_W'(i);
            end
        end
    end

    // Sticky accumulation and saturating hit counter next-state.
    always_comb begin
        sticky_d    = (clear_sticky ? '0 : sticky_q) | (hit ? report_in : '0);
        hit_count_d = hit_count_q;
        if (hit && (hit_count_q != {CNT_W{1'b1}})) begin
            hit_count_d = hit_count_q + 1'b1;
        end
    end

    // Stage pass-through registers and accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            symbols_q   <= '0;
            reset_q     <= 1'b1;
            run_q       <= 1'b0;
            sticky_q    <= '0;
            hit_count_q <= '0;
        end else begin
            if (run) begin
                symbols_q <= top_symbols;
            end
            reset_q     <= reset;
            run_q       <= run;
            sticky_q    <= sticky_d;
            hit_count_q <= hit_count_d;
        end
    end

`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] rec_time_q;

    assign ts_d = run ? ts_q + 1'b1 : ts_q;

    // Free-running run-cycle counter; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign rec_time = rec_time_q;
`else
    localparam int unused_ts_w = TS_W;
`endif

    // Record FSM: one pending record; extra hits while pending only flag overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rec_valid_q    <= 1'b0;
            rec_index_q    <= '0;
            rec_overflow_q <= 1'b0;
`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
            rec_time_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_q     <= PEND;
                        rec_valid_q <= 1'b1;
                        rec_index_q <= hit_index;
`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
                        rec_time_q  <= ts_q;
`endif
                    end
                end
                PEND: begin
                    if (hit && rec_ack) begin
                        rec_index_q <= hit_index;
`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
                        rec_time_q  <= ts_q;
`endif
                    end else if (hit) begin
                        rec_overflow_q <= 1'b1;
                    end else if (rec_ack) begin
                        state_q     <= IDLE;
                        rec_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rec_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_symbols    = symbols_q;
    assign out_reset      = reset_q;
    assign out_run        = run_q;
    assign sticky_reports = sticky_q;
    assign hit_count      = hit_count_q;
    assign rec_valid      = rec_valid_q;
    assign rec_index      = rec_index_q;
    assign rec_overflow   = rec_overflow_q;

endmodule

// File: tb/tb_automata_stage_collector.sv
// tb/tb_automata_stage_collector.sv - scoreboard bench for automata_stage_collector
module tb_automata_stage_collector;

    localparam int SW = 8;
    localparam int NR = 52;
    localparam int CW = 4;
    localparam int TW = 32;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [SW-1:0] top_symbols = '0;
    logic [NR-1:0] report_in = '0;
    logic          clear_sticky = 1'b0;
    logic          rec_ack = 1'b0;
    logic [SW-1:0] out_symbols;
    logic          out_reset;
    logic          out_run;
    logic [NR-1:0] sticky_reports;
    logic [CW-1:0] hit_count;
    logic          rec_valid;
    logic [IW-1:0] rec_index;
    logic          rec_overflow;
    logic [TW-1:0] rec_time_w;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    automata_stage_collector #(
        .SYMBOL_W(SW), .NUM_REPORTS(NR), .CNT_W(CW), .TS_W(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .top_symbols(top_symbols),
        .report_in(report_in),
        .clear_sticky(clear_sticky),
        .rec_ack(rec_ack),
        .out_symbols(out_symbols),
        .out_reset(out_reset),
        .out_run(out_run),
        .sticky_reports(sticky_reports),
        .hit_count(hit_count),
        .rec_valid(rec_valid),
        .rec_index(rec_index),
`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
        .rec_time(rec_time_w),
`endif
        .rec_overflow(rec_overflow)
    );

`ifndef AUTOMATA_STAGE_TIMESTAMP_EN
    assign rec_time_w = '0;
`endif

    typedef struct {
        logic [SW-1:0] osym;
        logic          orst;
        logic          orun;
        logic [NR-1:0] sticky;
        logic [CW-1:0] cnt;
        logic          rv;
        logic [IW-1:0] idx;
        logic          ovf;
        logic [TW-1:0] ts;
        logic [8:0]    chk;
        int            id;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;

    localparam logic [8:0] ALL   = 9'h0FF;
    localparam logic [8:0] NOIDX = 9'h0BF;
    localparam logic [8:0] NOSYM = 9'h0FE;

    function automatic logic [NR-1:0] b(input int n);
        logic [NR-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic rst, input logic rn, input logic [SW-1:0] sym,
                        input logic [NR-1:0] rep, input logic clr, input logic ack,
                        input logic [SW-1:0] eos, input logic [NR-1:0] est,
                        input logic [CW-1:0] ecnt, input logic erv, input logic [IW-1:0] eidx,
                        input logic eovf, input logic [TW-1:0] ets, input logic [8:0] chk);
        exp_t e;
        @(negedge clk);
        reset = rst; run = rn; top_symbols = sym; report_in = rep;
        clear_sticky = clr; rec_ack = ack;
        e.osym = eos; e.orst = rst; e.orun = rn & ~rst; e.sticky = est; e.cnt = ecnt;
        e.rv = erv; e.idx = eidx; e.ovf = eovf; e.ts = ets; e.chk = chk;
        step_id++;
        e.id = step_id;
        sb.push_back(e);
    endtask

    task automatic cmp(input int id, input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, name, act, req);
        end
    endtask

    // Monitor: after each edge, pop the expected state and compare selected fields.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk[0]) cmp(e.id, "out_symbols", 64'(out_symbols), 64'(e.osym));
                if (e.chk[1]) cmp(e.id, "out_reset", 64'(out_reset), 64'(e.orst));
                if (e.chk[2]) cmp(e.id, "out_run", 64'(out_run), 64'(e.orun));
                if (e.chk[3]) cmp(e.id, "sticky", 64'(sticky_reports), 64'(e.sticky));
                if (e.chk[4]) cmp(e.id, "hit_count", 64'(hit_count), 64'(e.cnt));
                if (e.chk[5]) cmp(e.id, "rec_valid", 64'(rec_valid), 64'(e.rv));
                if (e.chk[6]) cmp(e.id, "rec_index", 64'(rec_index), 64'(e.idx));
                if (e.chk[7]) cmp(e.id, "rec_overflow", 64'(rec_overflow), 64'(e.ovf));
                if (e.chk[8]) cmp(e.id, "rec_time", 64'(rec_time_w), 64'(e.ts));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] st;
        logic [CW-1:0] c;
        // reset overrides run/report/ack
        step(1, 1, 8'h55, b(0), 0, 1, 8'h00, '0, 0, 0, 0, 0, 0, ALL);
        step(0, 0, 8'h11, '0,   0, 0, 8'h00, '0, 0, 0, 0, 0, 0, ALL);
        // symbol load then hold across run=0; report/ack ignored when not running
        step(0, 1, 8'h41, '0,   0, 0, 8'h41, '0, 0, 0, 0, 0, 0, ALL);
        step(0, 0, 8'h99, '0,   0, 0, 8'h41, '0, 0, 0, 0, 0, 0, ALL);
        step(0, 0, 8'h98, b(1), 0, 0, 8'h41, '0, 0, 0, 0, 0, 0, ALL);
        step(0, 0, 8'h97, '0,   0, 1, 8'h41, '0, 0, 0, 0, 0, 0, ALL);
        // first hit, bits 5 and 9
        st = b(5) | b(9);
        step(0, 1, 8'h42, st, 0, 0, 8'h42, st, 1, 1, 5, 0, 0, ALL);
        // hit while pending without ack: held record, overflow
        st = st | b(3);
        step(0, 1, 8'h43, b(3), 0, 0, 8'h43, st, 2, 1, 5, 1, 0, ALL);
        // ack with hit: back-to-back capture
        st = st | b(7);
        step(0, 1, 8'h44, b(7), 0, 1, 8'h44, st, 3, 1, 7, 1, 0, ALL);
        // ack without hit (run=0): return to idle
        step(0, 0, 8'h45, b(20), 0, 1, 8'h44, st, 3, 0, 0, 1, 0, NOIDX);
        step(0, 0, 8'h46, '0,    0, 1, 8'h44, st, 3, 0, 0, 1, 0, NOIDX);
        // 20 hits: counter saturates at 15, record holds index 10
        for (int i = 0; i < 20; i++) begin
            st = st | b(10 + i);
            c = (3 + i + 1 >= 15) ? 4'd15 : CW'(3 + i + 1);
            step(0, 1, SW'(i), b(10 + i), 0, 0, SW'(i), st, c, 1, 10, 1, 0, ALL);
        end
        // same-cycle clear and report leaves only the new bit
        step(0, 1, 8'h60, b(2), 1, 1, 8'h60, b(2), 15, 1, 2, 1, 0, ALL);
        // lowest set bit wins
        st = b(2) | b(30) | b(51);
        step(0, 1, 8'h61, b(51) | b(30), 0, 1, 8'h61, st, 15, 1, 30, 1, 0, ALL);
        step(0, 1, 8'h62, b(51), 0, 1, 8'h62, st, 15, 1, 51, 1, 0, ALL);
        // reset while pending discards record and clears everything
        step(1, 1, 8'h63, b(1), 0, 0, 8'h00, '0, 0, 0, 0, 0, 0, ALL);
        // timestamp: 9 run cycles (with a run=0 gap) before the hit on the 10th
        for (int i = 0; i < 5; i++)
            step(0, 1, 8'h70, '0, 0, 0, 8'h70, '0, 0, 0, 0, 0, 0, NOSYM);
        for (int i = 0; i < 3; i++)
            step(0, 0, 8'h71, '0, 0, 0, 8'h70, '0, 0, 0, 0, 0, 0, ALL);
        for (int i = 0; i < 4; i++)
            step(0, 1, 8'h72, '0, 0, 0, 8'h72, '0, 0, 0, 0, 0, 0, ALL);
`ifdef AUTOMATA_STAGE_TIMESTAMP_EN
        step(0, 1, 8'h7A, b(0), 0, 0, 8'h7A, b(0), 1, 1, 0, 0, 9, ALL | 9'h100);
`else
        step(0, 1, 8'h7A, b(0), 0, 0, 8'h7A, b(0), 1, 1, 0, 0, 9, ALL);
`endif
        step(0, 0, 8'h00, '0, 0, 1, 8'h7A, b(0), 1, 0, 0, 0, 0, NOIDX);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
